// File: rtl/vco_adc_pkg.sv
// Shared constants for the VCO-ADC decimation chain: widths, half-band
// coefficients (Q1.15, taps 0..centre) and half-band FSM state encoding.
package vco_adc_pkg;

  localparam int CIC_OUT_W    = 16;
  localparam int HB_NTAPS     = 15;
  localparam int HB_ACC_W     = 36;
  localparam int HB_NCOEF     = (HB_NTAPS + 1) / 2;
  localparam int HB_COEF_W    = 16;
  localparam int HB_OUT_SHIFT = 15;

  localparam logic [1:0] HB_ST_IDLE  = 2'd0;
  localparam logic [1:0] HB_ST_MAC   = 2'd1;
  localparam logic [1:0] HB_ST_ROUND = 2'd2;
  localparam logic [1:0] HB_ST_OUT   = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE  = HB_ST_IDLE,
    ST_MAC   = HB_ST_MAC,
    ST_ROUND = HB_ST_ROUND,
    ST_OUT   = HB_ST_OUT
  } hb_state_e;

  // Index 7 is the centre tap; the odd taps of a half-band are zero.
  function automatic logic signed [HB_COEF_W-1:0] hb_coef(input int k);
    case (k)
      0:       return -16'sd96;
      2:       return 16'sd512;
      4:       return -16'sd1568;
      6:       return 16'sd9344;
      7:       return 16'sd16384;
      default: return 16'sd0;
    endcase
  endfunction

endpackage

// File: rtl/hb_mac.sv
// Half-band datapath: symmetric pre-add, signed multiply and wide accumulator
// with synchronous clear (priority) and accumulate enable.
module hb_mac
  import vco_adc_pkg::*;
#(
  parameter int DATA_W = CIC_OUT_W,
  parameter int COEF_W = HB_COEF_W,
  parameter int ACC_W  = HB_ACC_W
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     clr,
  input  logic                     en,
  input  logic signed [DATA_W-1:0] a,
  input  logic signed [DATA_W-1:0] b,
  input  logic signed [COEF_W-1:0] coef,
  output logic signed [ACC_W-1:0]  acc
);

  localparam int PROD_W = DATA_W + 1 + COEF_W;

  logic signed [DATA_W:0]   pre_sum;
  logic signed [PROD_W-1:0] prod;

  assign pre_sum = {a[DATA_W-1], a} + {b[DATA_W-1], b};
  assign prod    = pre_sum * coef;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc <= '0;
    end else if (clr) begin
      acc <= '0;
    end else if (en) begin
      acc <= acc + {{(ACC_W-PROD_W){prod[PROD_W-1]}}, prod};
    end
  end

endmodule

// File: rtl/halfband_decim.sv
// 15-tap half-band decimate-by-2 FIR, time-multiplexed over one MAC.
// Handshake: a sample is taken when enable_in & data_valid_in and the FSM is IDLE;
// strobes seen while busy are dropped and flagged on overrun_out.
module halfband_decim
  import vco_adc_pkg::*;
#(
  parameter int DATA_W    = CIC_OUT_W,
  parameter int NTAPS     = HB_NTAPS,
  parameter int ACC_W     = HB_ACC_W,
  parameter int OUT_SHIFT = HB_OUT_SHIFT
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     enable_in,
  input  logic signed [DATA_W-1:0] data_in,
  input  logic                     data_valid_in,
  input  logic                     ovr_clr_in,
  output logic signed [DATA_W-1:0] data_out,
  output logic                     data_valid_out,
  output logic                     busy_out,
  output logic                     overrun_out
);

  localparam int NCOEF = (NTAPS + 1) / 2;
  localparam int PTR_W = $clog2(NTAPS);
  localparam int IDX_W = PTR_W + 1;
  localparam int KW    = $clog2(NCOEF);

  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(NTAPS - 1);
  localparam logic [IDX_W-1:0] NTAPS_I  = IDX_W'(NTAPS);
  localparam logic [IDX_W-1:0] TAIL_I   = IDX_W'(NTAPS - 1);
  localparam logic [KW-1:0]    K_LAST   = KW'(NCOEF - 1);

  localparam logic signed [ACC_W-1:0] SAT_MAX  = ACC_W'(2**(DATA_W-1) - 1);
  localparam logic signed [ACC_W-1:0] SAT_MIN  = ~SAT_MAX;
  localparam logic signed [ACC_W-1:0] RND_HALF = ACC_W'(2**(OUT_SHIFT-1));

  hb_state_e                state;
  logic signed [DATA_W-1:0] buffer [NTAPS];
  logic [PTR_W-1:0]         wr_ptr;
  logic [KW-1:0]            k;
  // phase=1 means the first sample of an output pair is already held
  logic                     phase;
  logic signed [DATA_W-1:0] r_reg;

  logic                     accept;
  logic                     start;
  logic [IDX_W-1:0]         old_raw;
  logic [IDX_W-1:0]         new_raw;
  logic [PTR_W-1:0]         idx_old;
  logic [PTR_W-1:0]         idx_new;
  logic signed [DATA_W-1:0] mac_a;
  logic signed [DATA_W-1:0] mac_b;
  logic signed [ACC_W-1:0]  acc;
  logic signed [ACC_W-1:0]  rounded;
  logic signed [DATA_W-1:0] r_next;

  assign accept   = enable_in & data_valid_in & (state == ST_IDLE);
  assign start    = accept & phase;
  assign busy_out = (state != ST_IDLE);

  // During MAC wr_ptr points at the oldest sample; newest sits just behind it.
  always_comb begin
    old_raw = IDX_W'(wr_ptr) + IDX_W'(k);
    new_raw = IDX_W'(wr_ptr) + TAIL_I - IDX_W'(k);
    idx_old = (old_raw >= NTAPS_I) ? PTR_W'(old_raw - NTAPS_I) : PTR_W'(old_raw);
    idx_new = (new_raw >= NTAPS_I) ? PTR_W'(new_raw - NTAPS_I) : PTR_W'(new_raw);
    mac_a   = buffer[idx_new];
    // On the last step both pointers meet at the centre tap, which is added once.
    mac_b   = (k == K_LAST) ? '0 : buffer[idx_old];
  end

  hb_mac #(
    .DATA_W (DATA_W),
    .COEF_W (HB_COEF_W),
    .ACC_W  (ACC_W)
  ) u_mac (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (state == ST_IDLE),
    .en    (state == ST_MAC),
    .a     (mac_a),
    .b     (mac_b),
    .coef  (hb_coef(int'(k))),
    .acc   (acc)
  );

  always_comb begin
    rounded = (acc + RND_HALF) >>> OUT_SHIFT;
    if (rounded > SAT_MAX) begin
      r_next = SAT_MAX[DATA_W-1:0];
    end else if (rounded < SAT_MIN) begin
      r_next = SAT_MIN[DATA_W-1:0];
    end else begin
      r_next = rounded[DATA_W-1:0];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= ST_IDLE;
      wr_ptr         <= '0;
      k              <= '0;
      phase          <= 1'b0;
      r_reg          <= '0;
      data_out       <= '0;
      data_valid_out <= 1'b0;
      overrun_out    <= 1'b0;
      for (int i = 0; i < NTAPS; i++) begin
        buffer[i] <= '0;
      end
    end else begin
      data_valid_out <= 1'b0;

      if (accept) begin
        buffer[wr_ptr] <= data_in;
        wr_ptr         <= (wr_ptr == PTR_LAST) ? '0 : wr_ptr + 1'b1;
      end

      if (!enable_in) begin
        phase <= 1'b0;
      end else if (accept) begin
        phase <= ~phase;
      end

      if (enable_in && data_valid_in && state != ST_IDLE) begin
        overrun_out <= 1'b1;
      end else if (ovr_clr_in) begin
        overrun_out <= 1'b0;
      end

      case (state)
        ST_IDLE: begin
          k <= '0;
          if (start) begin
            state <= ST_MAC;
          end
        end
        ST_MAC: begin
          if (k == K_LAST) begin
            state <= ST_ROUND;
          end else begin
            k <= k + 1'b1;
          end
        end
        ST_ROUND: begin
          r_reg <= r_next;
          state <= ST_OUT;
        end
        ST_OUT: begin
          data_out       <= r_reg;
          data_valid_out <= 1'b1;
          state          <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_halfband_decim.sv
// Bench for halfband_decim: table-driven vectors plus hand-written corner
// sequences, with an expected-output queue checked against every output strobe.
module tb_halfband_decim;

  typedef struct {
    int din;
    bit chk;
    int exp;
  } vec_t;

  logic               clk = 1'b0;
  logic               rst_n;
  logic               enable_in;
  logic signed [15:0] data_in;
  logic               data_valid_in;
  logic               ovr_clr_in;
  logic signed [15:0] data_out;
  logic               data_valid_out;
  logic               busy_out;
  logic               overrun_out;

  int errors = 0;
  int checks = 0;
  int ncyc   = 0;
  int last_out = 0;

  logic signed [15:0] exp_q[$];
  int                 cyc_q[$];

  int h_tab[15]  = '{-96, 0, 512, 0, -1568, 0, 9344, 16384, 9344, 0, -1568, 0, 512, 0, -96};
  int imp_exp[9] = '{-96, 512, -1568, 9344, 9344, -1568, 512, -96, 0};
  int hist[15];
  bit tb_phase;
  vec_t tab[50];

  halfband_decim dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .enable_in      (enable_in),
    .data_in        (data_in),
    .data_valid_in  (data_valid_in),
    .ovr_clr_in     (ovr_clr_in),
    .data_out       (data_out),
    .data_valid_out (data_valid_out),
    .busy_out       (busy_out),
    .overrun_out    (overrun_out)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL global_timeout: got no finish, expected finish before 1ms");
    $fatal(1, "timeout");
  end

  // ---------------- reference model ----------------
  function automatic int model_out();
    longint s = 0;
    for (int j = 0; j < 15; j++) s += longint'(h_tab[j]) * longint'(hist[j]);
    s = (s + 64'sd16384) >>> 15;
    if (s > 32767) s = 32767;
    if (s < -32768) s = -32768;
    return int'(s);
  endfunction

  task automatic model_reset();
    for (int j = 0; j < 15; j++) hist[j] = 0;
    tb_phase = 1'b0;
  endtask

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) tick();
  endtask

  // One-cycle strobe. acc tells the model whether the DUT must take the sample.
  task automatic drive(input int s, input bit acc, input bit use_tab, input int tab_exp);
    data_in       = 16'(s);
    data_valid_in = 1'b1;
    if (acc) begin
      for (int j = 14; j > 0; j--) hist[j] = hist[j-1];
      hist[0] = s;
      if (tb_phase) begin
        exp_q.push_back(16'(use_tab ? tab_exp : model_out()));
        cyc_q.push_back(ncyc + 12);
      end
      tb_phase = ~tb_phase;
    end
    tick();
    data_valid_in = 1'b0;
  endtask

  task automatic send12(input int s, input bit use_tab, input int tab_exp);
    drive(s, 1'b1, use_tab, tab_exp);
    idle(11);
  endtask

  task automatic drain();
    int budget = 40;
    while (exp_q.size() > 0 && budget > 0) begin
      tick();
      budget--;
    end
    if (exp_q.size() > 0) begin
      check("drain_timeout", exp_q.size(), 0);
      exp_q.delete();
      cyc_q.delete();
    end
  endtask

  // ---------------- scoreboard ----------------
  always @(negedge clk) begin
    ncyc++;
    if (rst_n === 1'b1) begin
      if (data_valid_out) begin
        if (exp_q.size() == 0) begin
          check("unexpected_valid", int'(data_valid_out), 0);
        end else begin
          check("data_out", int'(data_out), int'(exp_q.pop_front()));
          check("latency", ncyc, cyc_q.pop_front());
          last_out = int'(data_out);
        end
      end else if (cyc_q.size() > 0 && ncyc > cyc_q[0]) begin
        check("missing_valid", int'(data_valid_out), 1);
        void'(exp_q.pop_front());
        void'(cyc_q.pop_front());
      end
    end
  end

  // ---------------- test ----------------
  initial begin
    bit busy_seen;
    int sgn;

    for (int i = 0; i < 18; i++) begin
      tab[i].din = (i == 1) ? 32767 : 0;
      tab[i].chk = 1'b1;
      tab[i].exp = (i % 2 == 1) ? imp_exp[i/2] : 0;
    end
    for (int m = 0; m < 2; m++) begin
      tab[18 + 16*m].din = 0;
      tab[18 + 16*m].chk = 1'b0;
      tab[18 + 16*m].exp = 0;
      for (int n = 0; n < 15; n++) begin
        sgn = (h_tab[n] < 0) ? -1 : 1;
        if (m == 1) sgn = -sgn;
        tab[19 + 16*m + n].din = sgn * 32767;
        tab[19 + 16*m + n].chk = (n == 14);
        tab[19 + 16*m + n].exp = (m == 0) ? 32767 : -32768;
      end
    end

    // 1) reset state
    rst_n = 1'b0; enable_in = 1'b0; data_in = '0; data_valid_in = 1'b0; ovr_clr_in = 1'b0;
    model_reset();
    idle(3);
    check("rst_data_out", int'(data_out), 0);
    check("rst_valid", int'(data_valid_out), 0);
    check("rst_busy", int'(busy_out), 0);
    check("rst_overrun", int'(overrun_out), 0);
    rst_n = 1'b1;
    enable_in = 1'b1;
    busy_seen = 1'b0;
    for (int i = 0; i < 100; i++) begin
      tick();
      if (busy_out) busy_seen = 1'b1;
    end
    check("idle_busy", int'(busy_seen), 0);

    // 2) impulse and saturation table
    for (int i = 0; i < 50; i++) send12(tab[i].din, tab[i].chk, tab[i].exp);
    drain();

    // 3) DC gain
    for (int i = 0; i < 40; i++) send12(1000, 1'b0, 0);
    drain();
    check("dc_final", last_out, 1000);

    // 4) overrun: strobes at +4 and +8 while busy, clear on the +8 one
    drive(700, 1'b1, 1'b0, 0);
    idle(11);
    drive(-300, 1'b1, 1'b0, 0);
    idle(3);
    drive(1234, 1'b0, 1'b0, 0);
    check("overrun_set", int'(overrun_out), 1);
    idle(3);
    ovr_clr_in = 1'b1;
    drive(9999, 1'b0, 1'b0, 0);
    ovr_clr_in = 1'b0;
    check("overrun_set_wins", int'(overrun_out), 1);
    idle(5);
    drain();
    ovr_clr_in = 1'b1;
    tick();
    ovr_clr_in = 1'b0;
    check("overrun_clear", int'(overrun_out), 0);
    send12(800, 1'b0, 0);
    send12(-900, 1'b0, 0);
    drain();

    // 5) enable dropped mid-MAC, then dropped while half a pair is held
    drive(1000, 1'b1, 1'b0, 0);
    idle(11);
    drive(1000, 1'b1, 1'b0, 0);
    idle(2);
    enable_in = 1'b0;
    tb_phase = 1'b0;
    drive(777, 1'b0, 1'b0, 0);
    idle(10);
    enable_in = 1'b1;
    check("no_overrun_when_disabled", int'(overrun_out), 0);
    drain();
    send12(2000, 1'b0, 0);
    enable_in = 1'b0;
    tb_phase = 1'b0;
    idle(3);
    enable_in = 1'b1;
    send12(3000, 1'b0, 0);
    send12(-2500, 1'b0, 0);
    drain();

    // 6) async reset mid-MAC: no output, everything cleared
    send12(500, 1'b0, 0);
    drive(600, 1'b1, 1'b0, 0);
    idle(3);
    rst_n = 1'b0;
    exp_q.delete();
    cyc_q.delete();
    model_reset();
    #1;
    check("midrst_data_out", int'(data_out), 0);
    check("midrst_valid", int'(data_valid_out), 0);
    check("midrst_busy", int'(busy_out), 0);
    check("midrst_overrun", int'(overrun_out), 0);
    tick();
    rst_n = 1'b1;
    idle(20);
    check("post_rst_data_out", int'(data_out), 0);
    check("post_rst_busy", int'(busy_out), 0);
    send12(-4000, 1'b0, 0);
    send12(4000, 1'b0, 0);
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
